seq_detect_scheduler: RTL and testbench

//  Shares one 1011 serial pattern detector between NUM_CH requesters. Round-robin

---
 rtl/seq_detect_scheduler.sv | 142 ++++++++++++++
 tb/tb_seq_detect_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_scheduler.sv
// Round-robin shares one overlapping 1011 detector among NUM_CH frame requesters.
// Latency: accept at cycle 0, rsp_valid at cycle FRAME_W+1; min FRAME_W+2 cycles/frame.
// Backpressure: req_ready only in IDLE; RESP holds result stable until rsp_ready.
module seq_detect_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int FRAME_W = 16,
    parameter int CH_W    = 2,
    parameter int CNT_W   = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         req_valid,
    input  logic [NUM_CH*FRAME_W-1:0] req_data,
    output logic [NUM_CH-1:0]         req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [CH_W-1:0]           rsp_ch,
    output logic [CNT_W-1:0]          rsp_count,
    output logic                      rsp_hit,
    output logic                      busy
);

    localparam int BIT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;
    typedef enum logic [1:0] {D_S0, D_S1, D_S10, D_S101} det_t;

    state_t             state, state_nxt;
    det_t               det, det_nxt;
    logic               match;
    logic [FRAME_W-1:0] shift_reg;
    logic [BIT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   count;
    logic [CH_W-1:0]    ch;
    logic [CH_W-1:0]    last_grant;
    logic [CH_W-1:0]    grant_idx;
    logic [CH_W-1:0]    scan;
    logic               grant_found;
    logic [FRAME_W-1:0] grant_data;
    logic               cur_bit;

    // Search starts one past the last served channel, wrapping modulo NUM_CH.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        scan        = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            scan = CH_W'((int'(last_grant) + i) % NUM_CH);
            if (!grant_found && req_valid[scan]) begin
                grant_found = 1'b1;
                grant_idx   = scan;
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_idx == CH_W'(i)) begin
                grant_data = req_data[i*FRAME_W +: FRAME_W];
            end
        end
    end

    assign cur_bit = shift_reg[FRAME_W-1];

    always_comb begin
        state_nxt = state;
        det_nxt   = det;
        match     = 1'b0;
        case (state)
            IDLE:    if (grant_found) state_nxt = SHIFT;
            SHIFT:   if (bit_cnt == '0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        case (det)
            D_S0:   det_nxt = cur_bit ? D_S1 : D_S0;
            D_S1:   det_nxt = cur_bit ? D_S1 : D_S10;
            D_S10:  det_nxt = cur_bit ? D_S101 : D_S0;
            D_S101: begin
                if (cur_bit) begin
                    match   = 1'b1;
                    det_nxt = D_S1;
                end else begin
                    det_nxt = D_S10;
                end
            end
            default: det_nxt = D_S0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            det        <= D_S0;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            count      <= '0;
            ch         <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        shift_reg <= grant_data;
                        ch        <= grant_idx;
                        count     <= '0;
                        det       <= D_S0;
                        bit_cnt   <= BIT_W'(FRAME_W - 1);
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_reg << 1;
                    det       <= det_nxt;
                    if (match && count != '1) count <= count + CNT_W'(1);
                    if (bit_cnt != '0) bit_cnt <= bit_cnt - BIT_W'(1);
                end
                RESP: begin
                    if (rsp_ready) last_grant <= ch;
                end
                default: ;
            endcase
        end
    end

    // Gated by reset so every output reads zero while reset is held.
    always_comb begin
        req_ready = '0;
        if (reset && state == IDLE && grant_found) begin
            req_ready = NUM_CH'(1) << grant_idx;
        end
    end

    assign rsp_valid = (state == RESP);
    assign rsp_ch    = ch;
    assign rsp_count = count;
    assign rsp_hit   = (count != '0);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed bench for seq_detect_scheduler: grant order, overlap counting, latency,
// backpressure hold and mid-frame reset, with hand-computed expectations.
module tb_seq_detect_scheduler;

    localparam int NUM_CH  = 4;
    localparam int FRAME_W = 16;
    localparam int CH_W    = 2;
    localparam int CNT_W   = 5;

    logic                      clk;
    logic                      reset;
    logic [NUM_CH-1:0]         req_valid;
    logic [NUM_CH*FRAME_W-1:0] req_data;
    logic [NUM_CH-1:0]         req_ready;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [CH_W-1:0]           rsp_ch;
    logic [CNT_W-1:0]          rsp_count;
    logic                      rsp_hit;
    logic                      busy;

    int n_assert = 0;
    int n_fail   = 0;

    seq_detect_scheduler #(
        .NUM_CH (NUM_CH),
        .FRAME_W(FRAME_W),
        .CH_W   (CH_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_ch   (rsp_ch),
        .rsp_count(rsp_count),
        .rsp_hit  (rsp_hit),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Single-channel frame with rsp_ready high; checks grant, SHIFT gating, latency and result.
    task automatic run_frame(input int c, input logic [15:0] data, input int exp_cnt, input string tag);
        int cyc;
        @(negedge clk);
        req_data = '0;
        req_data[c*FRAME_W +: FRAME_W] = data;
        req_valid = NUM_CH'(1 << c);
        rsp_ready = 1'b1;
        #1 check({tag, "_grant"}, 32'(req_ready), 32'(1 << c));
        @(negedge clk); #1;
        check({tag, "_shift_busy_rdy"}, 32'({busy, req_ready}), 32'({1'b1, 4'b0000}));
        req_valid = '0;
        req_data  = '1;
        cyc = 1;
        while (!rsp_valid && cyc < 40) begin
            @(negedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(17));
        check({tag, "_ch"}, 32'(rsp_ch), 32'(c));
        check({tag, "_count"}, 32'(rsp_count), 32'(exp_cnt));
        check({tag, "_hit"}, 32'(rsp_hit), 32'(exp_cnt != 0));
        @(negedge clk); #1;
        check({tag, "_rsp_drop"}, 32'(rsp_valid), 32'(0));
    endtask

    int cyc;
    int exp4[4];
    logic seen;

    initial begin
        exp4      = '{1, 3, 0, 1};
        reset     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("reset_outputs", 32'({rsp_valid, busy, req_ready, rsp_ch, rsp_count, rsp_hit}), 32'(0));
        reset = 1'b1;

        // 1: single 1011 at the top of the frame
        run_frame(0, 16'hB000, 1, "t1");
        // 2: overlapping matches
        run_frame(2, 16'hB6C0, 3, "t2");
        // 3: edge patterns and no carry-over between frames
        run_frame(1, 16'h0000, 0, "t3a");
        run_frame(1, 16'hFFFF, 0, "t3b");
        run_frame(1, 16'h000B, 1, "t3c");
        run_frame(1, 16'h0001, 0, "t3d");
        run_frame(1, 16'h6000, 0, "t3e");

        // 4: all channels requesting from reset -> 0,1,2,3,0
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 4'b1111;
        req_data  = {16'h000B, 16'h0000, 16'hB6C0, 16'hB000};
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        check("t4_rdy_in_reset", 32'(req_ready), 32'(0));
        @(negedge clk);
        reset = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            cyc = 0;
            while (req_ready == '0 && cyc < 40) begin
                @(negedge clk); #1;
                cyc++;
            end
            check($sformatf("t4_grant%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
            cyc = 0;
            while (!rsp_valid && cyc < 40) begin
                @(negedge clk); #1;
                cyc++;
            end
            check($sformatf("t4_ch%0d", k), 32'(rsp_ch), 32'(k % 4));
            check($sformatf("t4_cnt%0d", k), 32'(rsp_count), 32'(exp4[k % 4]));
            if (k == 4) req_valid = '0;
        end

        // 5: backpressure in RESP, other requests and data churn ignored
        @(negedge clk);
        req_valid = 4'b1000;
        req_data  = '0;
        req_data[3*FRAME_W +: FRAME_W] = 16'hB000;
        rsp_ready = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < 40) begin
            @(negedge clk); #1;
            cyc++;
        end
        for (int k = 0; k < 10; k++) begin
            check($sformatf("t5_hold%0d", k),
                  32'({rsp_valid, busy, req_ready, rsp_ch, rsp_count, rsp_hit}),
                  32'({1'b1, 1'b1, 4'b0000, 2'd3, 5'd1, 1'b1}));
            req_valid = 4'b1111;
            req_data  = {4{16'hBBBB}};
            @(negedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        check("t5_release", 32'({rsp_valid, busy, req_ready}), 32'({1'b0, 1'b0, 4'b0001}));
        req_valid = '0;

        // 6: reset at the 8th SHIFT cycle aborts the frame
        @(negedge clk);
        req_valid = 4'b0001;
        req_data  = '0;
        req_data[0 +: FRAME_W] = 16'hB6C0;
        @(negedge clk); #1;
        req_valid = '0;
        repeat (7) @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        check("t6_abort_outputs", 32'({rsp_valid, busy, req_ready, rsp_ch, rsp_count, rsp_hit}), 32'(0));
        reset = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("t6_no_rsp", 32'(seen), 32'(0));
        run_frame(1, 16'hB000, 1, "t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
